// File: rtl/ebus_arbiter.sv
//
// ebus_arbiter
// ------------
// Time-shares the single multiplexed EBUS data path among NREQ requesters
// (EBOX CTL, PI, DTE20, RH20 channels). Ownership is granted round-robin,
// one requester at a time. Each tenure runs IDLE -> SETUP -> XFER -> TURN:
// a settling cycle before the owner drives and a turnaround cycle after.
// grant/drive are one-hot and select EBUS.data in the top-level mux, so at
// most one driver is ever enabled.
//
// Optional feature macro: EBUS_TIMEOUT_EN
//   defined   : an 8-bit XFER timer forces a revoke after TIMEOUT cycles,
//               pulsing tmo and latching the revoked owner in tmoIdx.
//   undefined : no timer; XFER lasts until done/req drop; tmo=0, tmoIdx=0.
//
// Parameters
//   NREQ     number of requesters, 2..8
//   TIMEOUT  XFER cycles before forced revoke (EBUS_TIMEOUT_EN only), 1..255
//
// Ports
//   clk        in   1      system clock, all state on rising edge
//   CROBAR_N   in   1      asynchronous active-low reset
//   req        in   NREQ   level request, held high for the whole tenure
//   done       in   NREQ   1-cycle completion pulse from the owner
//   grant      out  NREQ   one-hot, owner may set up address/function lines
//   drive      out  NREQ   one-hot, owner's EBUS driver enable
//   busy       out  1      a grant is active (SETUP or XFER)
//   tmo        out  1      1-cycle pulse on forced revoke
//   tmoIdx     out  3      index of the last revoked owner
//
`timescale 1ns/1ps

module ebus_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 31
) (
    input  logic            clk,
    input  logic            CROBAR_N,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] done,
    output logic [NREQ-1:0] grant,
    output logic [NREQ-1:0] drive,
    output logic            busy,
    output logic            tmo,
    output logic [2:0]      tmoIdx
);

    localparam int            IW     = $clog2(NREQ);
    localparam logic [IW-1:0] LAST   = IW'(NREQ - 1);
    localparam bit            CFG_OK = (NREQ >= 2) && (NREQ <= 8) &&
                                       (TIMEOUT >= 1) && (TIMEOUT <= 255);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_TURN
    } state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;

`ifdef EBUS_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);
    logic [7:0] timer;
`endif

    // Round-robin pick: rotate req so bit 0 is the requester at ptr, take
    // the lowest set bit, then add ptr back (mod NREQ).
    logic [2*NREQ-1:0] req_twice;
    logic [2*NREQ-1:0] req_shift;
    logic [NREQ-1:0]   req_rot;
    logic              win_found;
    logic [IW-1:0]     win_off;
    logic [IW:0]       win_sum;
    logic [IW-1:0]     win_idx;
    logic [IW-1:0]     ptr_next;

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        req_twice = {req, req};
        req_shift = req_twice >> ptr;
        req_rot   = req_shift[NREQ-1:0];
        win_found = 1'b0;
        win_off   = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!win_found && req_rot[j]) begin
                win_found = 1'b1;
                win_off   = IW'(j);
            end
        end
        win_sum = {1'b0, ptr} + {1'b0, win_off};
        if (win_sum >= (IW+1)'(NREQ)) begin
            win_idx = IW'(win_sum - (IW+1)'(NREQ));
        end else begin
            win_idx = IW'(win_sum);
        end
        ptr_next = (win_idx == LAST) ? '0 : win_idx + 1'b1;
    end

    // Single FSM; every output is a register so nothing from req/done
    // reaches grant/drive combinationally.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge CROBAR_N) begin
        // NOTE: only control state is reset; there is no storage array here
        // that would need a reset-free memory style.
        if (!CROBAR_N) begin
            state  <= S_IDLE;
            ptr    <= '0;
            owner  <= '0;
            grant  <= '0;
            drive  <= '0;
            busy   <= 1'b0;
`ifdef EBUS_TIMEOUT_EN
            tmo    <= 1'b0;
            tmoIdx <= '0;
            timer  <= '0;
`endif
        end else begin
`ifdef EBUS_TIMEOUT_EN
            tmo <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        state <= S_SETUP;
                        owner <= win_idx;
                        ptr   <= ptr_next;
                        grant <= NREQ'(1) << win_idx;
                        busy  <= 1'b1;
                    end
                end

                S_SETUP: begin
                    if (req[owner]) begin
                        state <= S_XFER;
                        drive <= grant;
`ifdef EBUS_TIMEOUT_EN
                        timer <= '0;
`endif
                    end else begin
                        // Owner abandoned before driving: straight to turnaround.
                        state <= S_TURN;
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end

                S_XFER: begin
                    // done wins over a coincident timeout.
                    if (done[owner] || !req[owner]) begin
                        state <= S_TURN;
                        grant <= '0;
                        drive <= '0;
                        busy  <= 1'b0;
                    end
`ifdef EBUS_TIMEOUT_EN
                    else if (timer == TMO_LIMIT) begin
                        state  <= S_TURN;
                        grant  <= '0;
                        drive  <= '0;
                        busy   <= 1'b0;
                        tmo    <= 1'b1;
                        tmoIdx <= 3'(owner);
                    end else begin
                        timer <= timer + 8'd1;
                    end
`endif
                end

                S_TURN: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifndef EBUS_TIMEOUT_EN
    assign tmo    = 1'b0;
    assign tmoIdx = 3'd0;
`endif

    // Bus-safety invariants; CFG_OK also flags an out-of-range build.
    assert property (@(posedge clk) disable iff (!CROBAR_N)
        CFG_OK && $onehot0(grant) && $onehot0(drive) &&
        ((drive & ~grant) == '0) && (busy == (|grant)));

endmodule
